// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back formatter.
// Aligns sub-word loads and selects the register-file write data.
module mem_wb_stage (
  input  logic        clk,
  input  logic        Reset,
  input  logic        En,
  input  logic        Flush,
  input  logic [31:0] M_PC,
  input  logic [31:0] M_ALUOut,
  input  logic [31:0] M_DMRead,
  input  logic [4:0]  M_A3,
  input  logic        M_RegWrite,
  input  logic [1:0]  M_WBSel,
  input  logic [2:0]  M_LoadType,
  output logic [31:0] W_PC,
  output logic [4:0]  W_A3,
  output logic        W_RegWrite,
  output logic [31:0] W_WD,
  output logic        W_FwdValid,
  output logic        W_AdEL
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] dm;
    logic [4:0]  a3;
    logic        rw;
    logic [1:0]  wbsel;
    logic [2:0]  lt;
  } mw_t;

  mw_t r;

  // Zero is a NOP: no write, ALU select, lw format.
  always_ff @(posedge clk) begin
    if (Reset || Flush) begin
      r <= '0;
    end else if (En) begin
      r <= '{pc: M_PC, alu: M_ALUOut, dm: M_DMRead,
             a3: M_A3, rw: M_RegWrite,
             wbsel: M_WBSel, lt: M_LoadType};
    end
  end

  logic [1:0]  off;
  logic [15:0] half;
  logic [7:0]  byt;
  logic [31:0] ld;
  logic        is_half;
  logic        is_byte;
  logic        is_load;
  logic        adel;

  assign off     = r.alu[1:0];
  assign is_half = (r.lt == 3'd1) || (r.lt == 3'd2);
  assign is_byte = (r.lt == 3'd3) || (r.lt == 3'd4);
  assign is_load = (r.wbsel == 2'd1);

  always_comb begin
    half = off[1] ? r.dm[31:16] : r.dm[15:0];
    byt  = r.dm[7:0];
    unique case (off)
      2'd0: byt = r.dm[7:0];
      2'd1: byt = r.dm[15:8];
      2'd2: byt = r.dm[23:16];
      2'd3: byt = r.dm[31:24];
      default: byt = r.dm[7:0];
    endcase
  end

  always_comb begin
    ld = r.dm;
    unique case (r.lt)
      3'd1: ld = {{16{half[15]}}, half};
      3'd2: ld = {16'h0, half};
      3'd3: ld = {{24{byt[7]}}, byt};
      3'd4: ld = {24'h0, byt};
      default: ld = r.dm;
    endcase
  end

  // Unlisted load types behave as lw, so they need word alignment.
  assign adel = is_load &&
                ((!is_half && !is_byte && off != 2'd0) ||
                 (is_half && off[0]));

  always_comb begin
    W_WD = r.alu;
    unique case (r.wbsel)
      2'd1: W_WD = ld;
      2'd2: W_WD = r.pc + 32'd8;
      default: W_WD = r.alu;
    endcase
    if (adel) W_WD = 32'h0;
  end

  assign W_PC       = r.pc;
  assign W_A3       = r.a3;
  assign W_AdEL     = adel;
  assign W_RegWrite = r.rw && !adel;
  assign W_FwdValid = W_RegWrite && (r.a3 != 5'd0);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage.
// Expected W outputs queue at drive time, compare one edge later.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        Reset, En, Flush;
  logic [31:0] M_PC, M_ALUOut, M_DMRead;
  logic [4:0]  M_A3;
  logic        M_RegWrite;
  logic [1:0]  M_WBSel;
  logic [2:0]  M_LoadType;
  logic [31:0] W_PC, W_WD;
  logic [4:0]  W_A3;
  logic        W_RegWrite, W_FwdValid, W_AdEL;

  mem_wb_stage dut (
    .clk(clk), .Reset(Reset), .En(En), .Flush(Flush),
    .M_PC(M_PC), .M_ALUOut(M_ALUOut), .M_DMRead(M_DMRead),
    .M_A3(M_A3), .M_RegWrite(M_RegWrite), .M_WBSel(M_WBSel),
    .M_LoadType(M_LoadType),
    .W_PC(W_PC), .W_A3(W_A3), .W_RegWrite(W_RegWrite),
    .W_WD(W_WD), .W_FwdValid(W_FwdValid), .W_AdEL(W_AdEL)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [4:0]  a3;
    logic        rw;
    logic [31:0] wd;
    logic        fwd;
    logic        adel;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    checks++;
    assert (obs === want) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, want);
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] dm, input logic [4:0] a3,
                       input logic rw, input logic [1:0] wb,
                       input logic [2:0] lt);
    M_PC = pc; M_ALUOut = alu; M_DMRead = dm; M_A3 = a3;
    M_RegWrite = rw; M_WBSel = wb; M_LoadType = lt;
  endtask

  task automatic expect_w(input string tag, input logic [31:0] pc,
                          input logic [4:0] a3, input logic rw,
                          input logic [31:0] wd, input logic fwd,
                          input logic adel);
    exp_t e;
    e.tag = tag; e.pc = pc; e.a3 = a3; e.rw = rw;
    e.wd = wd; e.fwd = fwd; e.adel = adel;
    q.push_back(e);
    last = e;
  endtask

  // Advance one edge, then check the oldest queued expectation.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    assert (q.size() > 0) passed++;
    else $error("FAIL queue: got empty want entry");
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, ".pc"},   W_PC, e.pc);
      chk({e.tag, ".a3"},   {27'h0, W_A3}, {27'h0, e.a3});
      chk({e.tag, ".rw"},   {31'h0, W_RegWrite}, {31'h0, e.rw});
      chk({e.tag, ".wd"},   W_WD, e.wd);
      chk({e.tag, ".fwd"},  {31'h0, W_FwdValid}, {31'h0, e.fwd});
      chk({e.tag, ".adel"}, {31'h0, W_AdEL}, {31'h0, e.adel});
    end
    @(negedge clk);
  endtask

  initial begin
    Reset = 1'b1; En = 1'b1; Flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    for (int i = 0; i < 2; i++) begin
      drive($urandom, $urandom, $urandom, 5'($urandom),
            1'b1, 2'($urandom), 3'($urandom));
      expect_w("reset", 0, 0, 0, 0, 0, 0);
      tick();
    end
    Reset = 1'b0;

    drive(32'h100, 32'h3, 32'h80FF7F01, 8, 1, 1, 3);
    expect_w("lb", 32'h100, 8, 1, 32'hFFFFFF80, 1, 0);
    tick();
    drive(32'h104, 32'h3, 32'h80FF7F01, 8, 1, 1, 4);
    expect_w("lbu", 32'h104, 8, 1, 32'h00000080, 1, 0);
    tick();
    drive(32'h108, 32'h1, 32'h80FF7F01, 9, 1, 1, 3);
    expect_w("lb_off1", 32'h108, 9, 1, 32'h0000007F, 1, 0);
    tick();

    drive(32'h10C, 32'h2, 32'h8001FFFF, 10, 1, 1, 1);
    expect_w("lh", 32'h10C, 10, 1, 32'hFFFF8001, 1, 0);
    tick();
    drive(32'h110, 32'h2, 32'h8001FFFF, 10, 1, 1, 2);
    expect_w("lhu", 32'h110, 10, 1, 32'h00008001, 1, 0);
    tick();
    drive(32'h114, 32'h0, 32'h8001FFFF, 10, 1, 1, 1);
    expect_w("lh_lo", 32'h114, 10, 1, 32'hFFFFFFFF, 1, 0);
    tick();
    drive(32'h118, 32'h1, 32'h8001FFFF, 10, 1, 1, 1);
    expect_w("lh_adel", 32'h118, 10, 0, 32'h0, 0, 1);
    tick();
    drive(32'h11C, 32'h6, 32'hCAFEBABE, 11, 1, 1, 0);
    expect_w("lw_adel", 32'h11C, 11, 0, 32'h0, 0, 1);
    tick();
    drive(32'h120, 32'h5, 32'hCAFEBABE, 11, 1, 1, 7);
    expect_w("lt7_adel", 32'h120, 11, 0, 32'h0, 0, 1);
    tick();

    drive(32'h00003010, 32'h55, 32'h0, 31, 1, 2, 0);
    expect_w("jal", 32'h00003010, 31, 1, 32'h00003018, 1, 0);
    tick();
    drive(32'hFFFFFFFC, 32'h55, 32'h0, 31, 1, 2, 0);
    expect_w("jal_wrap", 32'hFFFFFFFC, 31, 1, 32'h00000004, 1, 0);
    tick();
    drive(32'h124, 32'h3, 32'h0, 12, 1, 3, 0);
    expect_w("wbsel3", 32'h124, 12, 1, 32'h00000003, 1, 0);
    tick();

    drive(32'h200, 32'h100, 32'h12345678, 5, 1, 1, 0);
    expect_w("lw", 32'h200, 5, 1, 32'h12345678, 1, 0);
    tick();
    En = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive($urandom, $urandom, $urandom, 5'($urandom),
            1'($urandom), 2'($urandom), 3'($urandom));
      expect_w("stall", 32'h200, 5, 1, 32'h12345678, 1, 0);
      tick();
    end
    Flush = 1'b1;
    expect_w("flush", 0, 0, 0, 0, 0, 0);
    tick();
    Flush = 1'b0; En = 1'b1;

    drive(32'h300, 32'h5, 32'h0, 0, 1, 0, 0);
    expect_w("a3_zero", 32'h300, 0, 1, 32'h5, 0, 0);
    tick();

    En = 1'b0;
    drive(32'h400, 32'h9, 32'h0, 3, 1, 0, 0);
    Reset = 1'b1;
    expect_w("reset_stall", 0, 0, 0, 0, 0, 0);
    tick();
    Reset = 1'b0; En = 1'b1; Flush = 1'b1;
    expect_w("flush_en", 0, 0, 0, 0, 0, 0);
    tick();
    Flush = 1'b0;
    drive(32'h500, 32'hA5A5A5A5, 32'h0, 4, 1, 0, 0);
    expect_w("alu", 32'h500, 4, 1, 32'hA5A5A5A5, 1, 0);
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
